// File: rtl/gemm_accelerator_top.sv
// gemm_accelerator_top
//   Single-MAC matrix multiplier: C[M][N] = A[M][K] x B[K][N], all matrices
//   row-major at base address 0 in their own word-addressed SRAMs.
//   Loop order is m (outer), n, k (inner); each C word is written once, in
//   increasing address order.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   start_i                       start request (only looked at in IDLE)
//   M_size_i/K_size_i/N_size_i    unsigned dimensions, latched at start
//   sram_a_addr_o/sram_a_rdata_i  A read port, data one cycle after address
//   sram_b_addr_o/sram_b_rdata_i  B read port, data one cycle after address
//   sram_c_addr_o/sram_c_wdata_o  C write port, sram_c_we_o write strobe
//   done_o                        one-cycle completion pulse
module gemm_accelerator_top #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic        [SizeAddrWidth-1:0] M_size_i,
    input  logic        [SizeAddrWidth-1:0] K_size_i,
    input  logic        [SizeAddrWidth-1:0] N_size_i,
    output logic        [AddrWidth-1:0]     sram_a_addr_o,
    output logic        [AddrWidth-1:0]     sram_b_addr_o,
    output logic        [AddrWidth-1:0]     sram_c_addr_o,
    input  logic signed [InDataWidth-1:0]   sram_a_rdata_i,
    input  logic signed [InDataWidth-1:0]   sram_b_rdata_i,
    output logic signed [OutDataWidth-1:0]  sram_c_wdata_o,
    output logic                           sram_c_we_o,
    output logic                           done_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]                     state;
    logic [SizeAddrWidth-1:0]       m_sz, k_sz, n_sz;
    logic [SizeAddrWidth-1:0]       m_cnt, n_cnt, k_cnt;
    logic [AddrWidth-1:0]           a_base;     // m_cnt*K, kept incrementally
    logic [AddrWidth-1:0]           a_addr, b_addr, c_addr;
    logic signed [OutDataWidth-1:0] acc;
    // vld_pipe[0]: the address on the A/B ports is a live k
    // vld_pipe[1]: the read data on the A/B ports belongs to a live k
    logic [1:0]                     vld_pipe;

    logic signed [2*InDataWidth-1:0] prod;
    logic signed [OutDataWidth-1:0]  prod_ext;
    logic                            last_n, last_m;
    logic [AddrWidth-1:0]            nxt_base;
    logic [SizeAddrWidth-1:0]        nxt_n;

    assign prod     = sram_a_rdata_i * sram_b_rdata_i;
    assign prod_ext = OutDataWidth'(prod);

    // Next (m,n) after the element being written in WRITE.
    assign last_n   = (n_cnt == n_sz - SizeAddrWidth'(1));
    assign last_m   = (m_cnt == m_sz - SizeAddrWidth'(1));
    assign nxt_n    = last_n ? '0 : n_cnt + SizeAddrWidth'(1);
    assign nxt_base = last_n ? a_base + AddrWidth'(k_sz) : a_base;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            m_sz     <= '0;
            k_sz     <= '0;
            n_sz     <= '0;
            m_cnt    <= '0;
            n_cnt    <= '0;
            k_cnt    <= '0;
            a_base   <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
            c_addr   <= '0;
            acc      <= '0;
            vld_pipe <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        m_sz     <= M_size_i;
                        k_sz     <= K_size_i;
                        n_sz     <= N_size_i;
                        m_cnt    <= '0;
                        n_cnt    <= '0;
                        k_cnt    <= '0;
                        a_base   <= '0;
                        a_addr   <= '0;
                        b_addr   <= '0;
                        c_addr   <= '0;
                        acc      <= '0;
                        vld_pipe <= '0;
                        if (M_size_i == '0 || N_size_i == '0) begin
                            state <= ST_DONE;
                        end else if (K_size_i == '0) begin
                            // Empty dot product: write the cleared accumulator.
                            state <= ST_WRITE;
                        end else begin
                            state    <= ST_COMPUTE;
                            vld_pipe <= 2'b01;
                        end
                    end
                end

                ST_COMPUTE: begin
                    vld_pipe[1] <= vld_pipe[0];
                    if (vld_pipe[0]) begin
                        if (k_cnt == k_sz - SizeAddrWidth'(1)) begin
                            vld_pipe[0] <= 1'b0;
                        end else begin
                            k_cnt  <= k_cnt + SizeAddrWidth'(1);
                            a_addr <= a_addr + AddrWidth'(1);
                            b_addr <= b_addr + AddrWidth'(n_sz);
                        end
                    end
                    if (vld_pipe[1]) begin
                        acc <= acc + prod_ext;
                    end
                    // Data for the last k is in flight with nothing issued behind it.
                    if (vld_pipe[1] && !vld_pipe[0]) begin
                        state <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    acc    <= '0;
                    k_cnt  <= '0;
                    c_addr <= c_addr + AddrWidth'(1);
                    if (last_n && last_m) begin
                        state <= ST_DONE;
                    end else begin
                        n_cnt  <= nxt_n;
                        a_base <= nxt_base;
                        if (last_n) begin
                            m_cnt <= m_cnt + SizeAddrWidth'(1);
                        end
                        a_addr <= nxt_base;
                        b_addr <= AddrWidth'(nxt_n);
                        if (k_sz == '0) begin
                            state <= ST_WRITE;
                        end else begin
                            state    <= ST_COMPUTE;
                            vld_pipe <= 2'b01;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_a_addr_o  = a_addr;
    assign sram_b_addr_o  = b_addr;
    assign sram_c_addr_o  = c_addr;
    assign sram_c_wdata_o = acc;
    assign sram_c_we_o    = (state == ST_WRITE);
    assign done_o         = (state == ST_DONE);

endmodule

// File: tb/tb_gemm_accelerator_top.sv
// tb_gemm_accelerator_top
//   Table-driven bench for gemm_accelerator_top. SRAM models for A/B/C, a
//   golden row-major product pushed into a scoreboard queue at start, popped
//   and compared on every C write (sampled on the falling edge).
module tb_gemm_accelerator_top;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               start_i;
    logic [7:0]         M_size_i, K_size_i, N_size_i;
    logic [15:0]        sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic signed [7:0]  sram_a_rdata_i, sram_b_rdata_i;
    logic signed [31:0] sram_c_wdata_o;
    logic               sram_c_we_o;
    logic               done_o;

    always #5 clk_i = ~clk_i;

    gemm_accelerator_top dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .M_size_i       (M_size_i),
        .K_size_i       (K_size_i),
        .N_size_i       (N_size_i),
        .sram_a_addr_o  (sram_a_addr_o),
        .sram_b_addr_o  (sram_b_addr_o),
        .sram_c_addr_o  (sram_c_addr_o),
        .sram_a_rdata_i (sram_a_rdata_i),
        .sram_b_rdata_i (sram_b_rdata_i),
        .sram_c_wdata_o (sram_c_wdata_o),
        .sram_c_we_o    (sram_c_we_o),
        .done_o         (done_o)
    );

    logic signed [7:0]  mem_a [0:1023];
    logic signed [7:0]  mem_b [0:1023];
    logic signed [31:0] mem_c [0:1023];

    always @(posedge clk_i) begin
        sram_a_rdata_i <= mem_a[sram_a_addr_o[9:0]];
        sram_b_rdata_i <= mem_b[sram_b_addr_o[9:0]];
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        int              m, k, n, pat, writes;
        bit              hold, chk;
        logic [3:0][31:0] exp_c;
    } tv_t;
    tv_t tv [0:7];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act,
                     $signed(exp), exp);
        end
    endtask

    // C write monitor / scoreboard consumer.
    always @(negedge clk_i) begin
        if (sram_c_we_o) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d, no write expected",
                         sram_c_addr_o, sram_c_wdata_o);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("c_addr", 32'(sram_c_addr_o), 32'(e.addr));
                chk("c_data", sram_c_wdata_o, 32'(e.data));
            end
            mem_c[sram_c_addr_o[9:0]] = sram_c_wdata_o;
        end
        if (done_o) done_cnt++;
    end

    task automatic set_tv(input int i, input int m, k, n, pat, writes, input bit hold, chk_c,
                          input int c0, c1, c2, c3);
        tv[i].m = m; tv[i].k = k; tv[i].n = n; tv[i].pat = pat; tv[i].writes = writes;
        tv[i].hold = hold; tv[i].chk = chk_c;
        tv[i].exp_c = {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endtask

    task automatic load_and_push(input int m, k, n, pat);
        for (int i = 0; i < 1024; i++) begin
            case (pat)
                1:       begin mem_a[i] = 8'(i + 1); mem_b[i] = 8'(i + 7); end
                2:       begin mem_a[i] = -8'sd128;  mem_b[i] = -8'sd128; end
                default: begin mem_a[i] = 8'($urandom_range(0, 255));
                               mem_b[i] = 8'($urandom_range(0, 255)); end
            endcase
            mem_c[i] = 32'hDEAD_BEEF;
        end
        sb_q.delete();
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++) begin
                wr_t e;
                int sum;
                sum = 0;
                for (int ki = 0; ki < k; ki++)
                    sum += int'(mem_a[mi*k + ki]) * int'(mem_b[ki*n + ni]);
                e.addr = mi*n + ni;
                e.data = sum;
                sb_q.push_back(e);
            end
    endtask

    // Issue one start; with hold, start stays high and sizes are scrambled
    // until done is seen.
    task automatic launch(input int m, k, n, input bit hold);
        @(posedge clk_i); #1;
        wr_cnt = 0; done_cnt = 0;
        M_size_i = 8'(m); K_size_i = 8'(k); N_size_i = 8'(n);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        if (hold) begin
            M_size_i = 8'd3; K_size_i = 8'd5; N_size_i = 8'd7;
        end else begin
            start_i = 1'b0;
        end
    endtask

    task automatic run_case(input int idx);
        tv_t t;
        int bound;
        bit seen;
        t = tv[idx];
        load_and_push(t.m, t.k, t.n, t.pat);
        launch(t.m, t.k, t.n, t.hold);
        bound = t.m * t.n * (t.k + 2) + 4;
        seen = 1'b0;
        for (int cyc = 1; cyc <= bound; cyc++) begin
            @(negedge clk_i);
            if (done_o) begin seen = 1'b1; break; end
        end
        start_i = 1'b0;
        chk($sformatf("done_within_bound[%0d]", idx), 32'(seen), 32'd1);
        repeat (4) @(posedge clk_i);
        #1;
        chk($sformatf("write_count[%0d]", idx), 32'(wr_cnt), 32'(t.writes));
        chk($sformatf("done_count[%0d]", idx), 32'(done_cnt), 32'd1);
        chk($sformatf("sb_left[%0d]", idx), 32'(sb_q.size()), 32'd0);
        if (t.chk)
            for (int i = 0; i < t.writes && i < 4; i++)
                chk($sformatf("c_word[%0d][%0d]", idx, i), mem_c[i], t.exp_c[i]);
    endtask

    initial begin
        set_tv(0, 2, 3, 2, 1, 4,  0, 1, 58, 64, 139, 154);
        set_tv(1, 1, 1, 1, 2, 1,  0, 1, 16384, 0, 0, 0);
        set_tv(2, 2, 0, 2, 0, 4,  0, 1, 0, 0, 0, 0);
        set_tv(3, 0, 4, 3, 0, 0,  0, 0, 0, 0, 0, 0);
        set_tv(4, 3, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        set_tv(5, 8, 8, 8, 0, 64, 0, 0, 0, 0, 0, 0);
        set_tv(6, 3, 5, 4, 0, 12, 0, 0, 0, 0, 0, 0);
        set_tv(7, 2, 3, 2, 1, 4,  1, 1, 58, 64, 139, 154);

        rst_ni = 1'b0; start_i = 1'b0;
        M_size_i = '0; K_size_i = '0; N_size_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_we", 32'(sram_c_we_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_a_addr", 32'(sram_a_addr_o), 32'd0);
        chk("rst_b_addr", 32'(sram_b_addr_o), 32'd0);
        chk("rst_c_addr", 32'(sram_c_addr_o), 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) run_case(i);

        // Abort an 8x8x8 run with reset mid-way.
        load_and_push(8, 8, 8, 0);
        launch(8, 8, 8, 0);
        repeat (40) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(posedge clk_i); #1;
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            chk("abort_we", 32'(sram_c_we_o), 32'd0);
            chk("abort_done", 32'(done_o), 32'd0);
            @(posedge clk_i); #1;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        rst_ni = 1'b1;
        run_case(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
